// File: rtl/adau_init_sequencer_if.sv
// Command channel between the init sequencer and the codec control-port master.
// master = sequencer side (drives command), slave = control-port master side.
interface adau_init_sequencer_if;
    logic [23:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;

    modport master (output cmd_data, output cmd_valid, input cmd_ready);
    modport slave  (input cmd_data, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/adau_init_sequencer.sv
// ADAU codec power-up sequencer: walks a synchronous command ROM and issues
// register writes, timed delays and an END marker, then flags completion.
module adau_init_sequencer #(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned DELAY_W    = 24,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [31:0]           rom_data,
    adau_init_sequencer_if.master cmd,
    output logic                  busy,
    output logic                  adau_init_done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_WRITE = 4'h0;
    localparam logic [3:0] OP_DELAY = 4'h1;
    localparam logic [3:0] OP_END   = 4'hF;

    state_t               state;
    state_t               state_nxt;
    logic [DELAY_W-1:0]   delay_cnt;
    logic [23:0]          cmd_data_q;
    logic                 cmd_valid_q;

    logic [3:0]           opcode;
    logic [DELAY_W-1:0]   delay_n;
    logic                 is_write;
    logic                 is_delay;
    logic                 is_end;
    logic                 delay_zero;
    logic                 last_addr;
    logic                 advance;
    logic                 unused_rom_bits;

    assign opcode          = rom_data[31:28];
    assign delay_n         = rom_data[DELAY_W-1:0];
    assign is_write        = (opcode == OP_WRITE);
    assign is_delay        = (opcode == OP_DELAY);
    assign is_end          = (opcode == OP_END);
    assign delay_zero      = (delay_n == '0);
    assign last_addr       = (rom_addr == '1);
    assign unused_rom_bits = ^rom_data[27:24];

    assign cmd.cmd_data  = cmd_data_q;
    assign cmd.cmd_valid = cmd_valid_q;

    // One-cycle "move past this entry" strobe shared by NOP, DELAY 0, accept and delay expiry.
    always_comb begin
        advance = 1'b0;
        case (state)
            S_DECODE: advance = (is_delay && delay_zero) || (!is_write && !is_delay && !is_end);
            S_SEND:   advance = cmd_valid_q && cmd.cmd_ready;
            S_WAIT:   advance = (delay_cnt == DELAY_W'(1));
            default:  advance = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= AUTO_START ? S_FETCH : S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_write) begin
                    state_nxt = S_SEND;
                end else if (is_end) begin
                    state_nxt = S_DONE;
                end else if (is_delay && !delay_zero) begin
                    state_nxt = S_WAIT;
                end
            end
            S_DONE:   if (start) state_nxt = S_FETCH;
            default:  state_nxt = state;
        endcase
        if (advance) begin
            state_nxt = last_addr ? S_DONE : S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr       <= '0;
            cmd_data_q     <= '0;
            cmd_valid_q    <= 1'b0;
            adau_init_done <= 1'b0;
            err            <= 1'b0;
            delay_cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rom_addr <= '0;
                        err      <= 1'b0;
                    end
                end
                S_DECODE: begin
                    if (is_write) begin
                        cmd_data_q  <= rom_data[23:0];
                        cmd_valid_q <= 1'b1;
                    end else if (is_end) begin
                        adau_init_done <= 1'b1;
                    end else if (is_delay && !delay_zero) begin
                        delay_cnt <= delay_n;
                    end
                end
                S_SEND: begin
                    if (cmd.cmd_ready) cmd_valid_q <= 1'b0;
                end
                S_WAIT: begin
                    delay_cnt <= delay_cnt - DELAY_W'(1);
                end
                S_DONE: begin
                    if (start) begin
                        adau_init_done <= 1'b0;
                        err            <= 1'b0;
                        rom_addr       <= '0;
                    end
                end
                default: ;
            endcase
            // Running past the last ROM slot is treated as an unterminated sequence.
            if (advance) begin
                if (last_addr) begin
                    adau_init_done <= 1'b1;
                    err            <= 1'b1;
                end else begin
                    rom_addr <= rom_addr + ADDR_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy = !((state == S_IDLE) || (state == S_DONE));
    end

endmodule

// File: tb/tb_adau_init_sequencer.sv
// Directed bench for adau_init_sequencer: one auto-start 64-entry instance and
// one start-driven 4-entry instance, each with its own synchronous ROM model.
module tb_adau_init_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: ADDR_W=6, AUTO_START=1 ----------------
    logic        rst_a = 1'b1;
    logic        start_a = 1'b0;
    logic [5:0]  rom_addr_a;
    logic [31:0] rom_data_a;
    logic        busy_a, done_a, err_a;
    logic [31:0] rom_a [64];
    logic [23:0] hs_a [$];
    adau_init_sequencer_if if_a ();

    adau_init_sequencer #(.ADDR_W(6), .DELAY_W(24), .AUTO_START(1'b1)) dut_a (
        .clk(clk), .reset(rst_a), .start(start_a),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a), .cmd(if_a.master),
        .busy(busy_a), .adau_init_done(done_a), .err(err_a)
    );

    always @(posedge clk) rom_data_a <= rom_a[rom_addr_a];
    always @(posedge clk) if (!rst_a && if_a.cmd_valid && if_a.cmd_ready) hs_a.push_back(if_a.cmd_data);

    // ---------------- instance B: ADDR_W=2, AUTO_START=0 ----------------
    logic        rst_b = 1'b1;
    logic        start_b = 1'b0;
    logic [1:0]  rom_addr_b;
    logic [31:0] rom_data_b;
    logic        busy_b, done_b, err_b;
    logic [31:0] rom_b [4];
    logic [23:0] hs_b [$];
    adau_init_sequencer_if if_b ();

    adau_init_sequencer #(.ADDR_W(2), .DELAY_W(24), .AUTO_START(1'b0)) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b), .cmd(if_b.master),
        .busy(busy_b), .adau_init_done(done_b), .err(err_b)
    );

    always @(posedge clk) rom_data_b <= rom_b[rom_addr_b];
    always @(posedge clk) if (!rst_b && if_b.cmd_valid && if_b.cmd_ready) hs_b.push_back(if_b.cmd_data);

    task automatic load_a(input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
        for (int i = 0; i < 64; i++) rom_a[i] = 32'hF000_0000;
        rom_a[0] = e0; rom_a[1] = e1; rom_a[2] = e2; rom_a[3] = e3;
    endtask

    // Leaves reset asserted; caller releases it on a falling edge.
    task automatic hold_reset_a();
        @(negedge clk);
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        hs_a.delete();
    endtask

    task automatic wait_done_a(input string tag);
        int n = 0;
        while (!done_a && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(done_a), 32'h1);
    endtask

    task automatic wait_done_b(input string tag);
        int n = 0;
        while (!done_b && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(done_b), 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic seen;
        if_a.cmd_ready = 1'b1;
        if_b.cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) rom_b[i] = 32'h0000_0000;

        // Two writes plus END, with latency and write-to-write spacing
        load_a(32'h0040_000F, 32'h0040_1501, 32'hF000_0000, 32'hF000_0000);
        hold_reset_a();
        check("rst cmd_valid", 32'(if_a.cmd_valid), 32'h0);
        check("rst cmd_data", 32'(if_a.cmd_data), 32'h0);
        check("rst rom_addr", 32'(rom_addr_a), 32'h0);
        check("rst done", 32'(done_a), 32'h0);
        check("rst err", 32'(err_a), 32'h0);
        check("rst busy", 32'(busy_a), 32'h1);
        rst_a = 1'b0;
        @(negedge clk);
        check("lat edge1 valid", 32'(if_a.cmd_valid), 32'h0);
        @(negedge clk);
        check("lat edge2 valid", 32'(if_a.cmd_valid), 32'h1);
        check("lat edge2 data", 32'(if_a.cmd_data), 32'h40000F);
        @(negedge clk);
        check("w2w accept valid", 32'(if_a.cmd_valid), 32'h0);
        @(negedge clk);
        check("w2w decode valid", 32'(if_a.cmd_valid), 32'h0);
        @(negedge clk);
        check("w2w second valid", 32'(if_a.cmd_valid), 32'h1);
        check("w2w second data", 32'(if_a.cmd_data), 32'h401501);
        wait_done_a("two writes done");
        check("two writes count", 32'(hs_a.size()), 32'd2);
        check("two writes hs0", 32'(hs_a[0]), 32'h40000F);
        check("two writes hs1", 32'(hs_a[1]), 32'h401501);
        check("two writes busy", 32'(busy_a), 32'h0);
        check("two writes err", 32'(err_a), 32'h0);

        // Backpressure on the first write
        hold_reset_a();
        if_a.cmd_ready = 1'b0;
        rst_a = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp valid", 32'(if_a.cmd_valid), 32'h1);
            check("bp data", 32'(if_a.cmd_data), 32'h40000F);
        end
        check("bp no hs yet", 32'(hs_a.size()), 32'd0);
        if_a.cmd_ready = 1'b1;
        wait_done_a("bp done");
        check("bp count", 32'(hs_a.size()), 32'd2);
        check("bp hs0", 32'(hs_a[0]), 32'h40000F);
        check("bp hs1", 32'(hs_a[1]), 32'h401501);

        // DELAY 100 ahead of a write
        load_a(32'h1000_0064, 32'h0040_0A01, 32'hF000_0000, 32'hF000_0000);
        hold_reset_a();
        rst_a = 1'b0;
        k = 0;
        while (!if_a.cmd_valid && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("delay100 first valid", 32'(k), 32'd104);
        check("delay100 data", 32'(if_a.cmd_data), 32'h400A01);
        wait_done_a("delay100 done");
        check("delay100 count", 32'(hs_a.size()), 32'd1);

        // DELAY 0 takes no wait cycles
        load_a(32'h1000_0000, 32'h0040_0A01, 32'hF000_0000, 32'hF000_0000);
        hold_reset_a();
        rst_a = 1'b0;
        k = 0;
        while (!if_a.cmd_valid && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("delay0 first valid", 32'(k), 32'd4);
        wait_done_a("delay0 done");

        // NOP entry between two writes
        load_a(32'h0040_000F, 32'h5000_1234, 32'h0040_1501, 32'hF000_0000);
        hold_reset_a();
        rst_a = 1'b0;
        wait_done_a("nop done");
        check("nop count", 32'(hs_a.size()), 32'd2);
        check("nop hs0", 32'(hs_a[0]), 32'h40000F);
        check("nop hs1", 32'(hs_a[1]), 32'h401501);

        // Empty ROM: END at entry 0
        load_a(32'hF000_0000, 32'h0040_000F, 32'h0040_1501, 32'hF000_0000);
        hold_reset_a();
        rst_a = 1'b0;
        wait_done_a("empty done");
        check("empty count", 32'(hs_a.size()), 32'd0);
        check("empty err", 32'(err_a), 32'h0);

        // Reset during SEND, then restart from entry 0
        load_a(32'h0040_000F, 32'h0040_1501, 32'hF000_0000, 32'hF000_0000);
        hold_reset_a();
        if_a.cmd_ready = 1'b0;
        rst_a = 1'b0;
        repeat (2) @(negedge clk);
        check("midsend valid before", 32'(if_a.cmd_valid), 32'h1);
        rst_a = 1'b1;
        @(negedge clk);
        check("midsend valid after rst", 32'(if_a.cmd_valid), 32'h0);
        check("midsend done after rst", 32'(done_a), 32'h0);
        check("midsend addr after rst", 32'(rom_addr_a), 32'h0);
        rst_a = 1'b0;
        if_a.cmd_ready = 1'b1;
        wait_done_a("midsend rerun done");
        check("midsend rerun count", 32'(hs_a.size()), 32'd2);
        check("midsend rerun hs0", 32'(hs_a[0]), 32'h40000F);

        // Instance B: start together with reset, idle without start
        rom_b[0] = 32'h0000_0011; rom_b[1] = 32'h0000_0022;
        rom_b[2] = 32'h0000_0033; rom_b[3] = 32'h0000_0044;
        @(negedge clk);
        rst_b = 1'b1;
        start_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        start_b = 1'b0;
        hs_b.delete();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen = seen | if_b.cmd_valid;
        end
        check("idle no valid", 32'(seen), 32'h0);
        check("idle busy", 32'(busy_b), 32'h0);
        check("idle done", 32'(done_b), 32'h0);

        // Start, with extra start pulses while busy, running off the ROM end
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("start busy", 32'(busy_b), 32'h1);
        for (int i = 1; i < 10; i++) begin
            start_b = (i % 3 == 1);
            @(negedge clk);
        end
        start_b = 1'b0;
        wait_done_b("runoff done");
        check("runoff count", 32'(hs_b.size()), 32'd4);
        check("runoff hs0", 32'(hs_b[0]), 32'h11);
        check("runoff hs1", 32'(hs_b[1]), 32'h22);
        check("runoff hs2", 32'(hs_b[2]), 32'h33);
        check("runoff hs3", 32'(hs_b[3]), 32'h44);
        check("runoff err", 32'(err_b), 32'h1);
        check("runoff busy", 32'(busy_b), 32'h0);
        @(negedge clk);
        check("runoff err sticky", 32'(err_b), 32'h1);

        // Restart from DONE
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("restart err clr", 32'(err_b), 32'h0);
        check("restart done clr", 32'(done_b), 32'h0);
        check("restart addr", 32'(rom_addr_b), 32'h0);
        check("restart busy", 32'(busy_b), 32'h1);
        wait_done_b("restart done");
        check("restart count", 32'(hs_b.size()), 32'd8);
        check("restart hs4", 32'(hs_b[4]), 32'h11);
        check("restart err", 32'(err_b), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
